program_sequencer: RTL

PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

---
 rtl/program_sequencer.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/program_sequencer.sv
// Program sequencer: fetches instructions from a program BRAM, decodes END and
// LOOP control opcodes locally, and hands all other instructions to a datapath.
//
// Handshakes:
//   BRAM     - prog_re is a one-cycle request for prog_raddr. The response is
//              accepted on the first cycle in INSTRUCTION_RECEIVE that has
//              prog_rvalid=1. Any latency is allowed; there is no backpressure.
//   datapath - exec_start is a one-cycle issue pulse, and exec_instr holds
//              steady until completion. exec_done acts as a valid and is
//              accepted on any EXECUTE cycle after the exec_start cycle.
module program_sequencer #(
  parameter int LOG2_PROGRAM_SIZE = 5,
  parameter int INSTR_WIDTH       = 128
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic [LOG2_PROGRAM_SIZE:0]   program_length,
  input  logic                         abort,
  output logic                         prog_re,
  output logic [LOG2_PROGRAM_SIZE-1:0] prog_raddr,
  input  logic [INSTR_WIDTH-1:0]       prog_rdata,
  input  logic                         prog_rvalid,
  output logic                         exec_start,
  output logic [INSTR_WIDTH-1:0]       exec_instr,
  input  logic                         exec_done,
  output logic [LOG2_PROGRAM_SIZE-1:0] pc,
  output logic [2:0]                   state,
  output logic                         done
);

  localparam int AW = LOG2_PROGRAM_SIZE;
  localparam int LW = LOG2_PROGRAM_SIZE + 1;

  typedef enum logic [2:0] {
    IDLE                = 3'd0,
    INSTRUCTION_FETCH   = 3'd1,
    INSTRUCTION_RECEIVE = 3'd2,
    INSTRUCTION_DECODE  = 3'd3,
    EXECUTE             = 3'd4,
    DONE                = 3'd5
  } t_machinestate;

  t_machinestate state_q, next_state;
  logic [LW-1:0] length_q;
  logic          loop_active, next_loop_active;
  logic [15:0]   loop_remaining, next_loop_remaining;
  logic [AW-1:0] next_pc;
  logic          do_advance;

  logic [3:0]    opcode;
  logic [AW-1:0] loop_target;
  logic [15:0]   loop_count;
  logic [LW-1:0] pc_inc;

  assign opcode      = exec_instr[3:0];
  assign loop_target = exec_instr[4 +: AW];
  assign loop_count  = exec_instr[16 +: 16];
  assign pc_inc      = {1'b0, pc} + LW'(1);
  assign state       = state_q;

  // Next-state, program counter and loop bookkeeping.
  always_comb begin
    next_state          = state_q;
    next_pc             = pc;
    next_loop_active    = loop_active;
    next_loop_remaining = loop_remaining;
    do_advance          = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (program_length != '0) begin
            next_state          = INSTRUCTION_FETCH;
            next_pc             = '0;
            next_loop_active    = 1'b0;
            next_loop_remaining = '0;
          end else begin
            next_state = DONE;
          end
        end
      end
      INSTRUCTION_FETCH:   next_state = INSTRUCTION_RECEIVE;
      INSTRUCTION_RECEIVE: if (prog_rvalid) next_state = INSTRUCTION_DECODE;
      INSTRUCTION_DECODE: begin
        if (opcode == 4'h0) begin
          next_state = DONE;
        end else if (opcode == 4'h1) begin
          // A LOOP pointing outside the program is treated as termination.
          if ({1'b0, loop_target} >= length_q) begin
            next_state = DONE;
          end else if (!loop_active && loop_count != '0) begin
            next_loop_active    = 1'b1;
            next_loop_remaining = loop_count - 16'd1;
            next_pc             = loop_target;
            next_state          = INSTRUCTION_FETCH;
          end else if (loop_active && loop_remaining != '0) begin
            next_loop_remaining = loop_remaining - 16'd1;
            next_pc             = loop_target;
            next_state          = INSTRUCTION_FETCH;
          end else begin
            next_loop_active = 1'b0;
            do_advance       = 1'b1;
          end
        end else begin
          next_state = EXECUTE;
        end
      end
      // exec_done is ignored in the issue cycle (exec_start high).
      EXECUTE: if (exec_done && !exec_start) do_advance = 1'b1;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase

    // Sequential advance: stop at the last instruction, never wrap.
    if (do_advance) begin
      if (pc_inc == length_q) begin
        next_state = DONE;
      end else begin
        next_pc    = pc_inc[AW-1:0];
        next_state = INSTRUCTION_FETCH;
      end
    end

    // Abort wins over everything while a program is running.
    if (abort && state_q inside {INSTRUCTION_FETCH, INSTRUCTION_RECEIVE,
                                 INSTRUCTION_DECODE, EXECUTE}) begin
      next_state          = DONE;
      next_pc             = pc;
      next_loop_active    = loop_active;
      next_loop_remaining = loop_remaining;
    end
  end

  // State, program counter, loop state and latched length.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      pc             <= '0;
      loop_active    <= 1'b0;
      loop_remaining <= '0;
      length_q       <= '0;
    end else begin
      state_q        <= next_state;
      pc             <= next_pc;
      loop_active    <= next_loop_active;
      loop_remaining <= next_loop_remaining;
      if (state_q == IDLE && start) length_q <= program_length;
    end
  end

  // Registered outputs, decoded from the upcoming state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prog_re    <= 1'b0;
      prog_raddr <= '0;
      exec_start <= 1'b0;
      exec_instr <= '0;
      done       <= 1'b0;
    end else begin
      prog_re    <= (next_state == INSTRUCTION_FETCH);
      if (next_state == INSTRUCTION_FETCH) prog_raddr <= next_pc;
      exec_start <= (next_state == EXECUTE) && (state_q != EXECUTE);
      done       <= (next_state == DONE);
      if (state_q == INSTRUCTION_RECEIVE && next_state == INSTRUCTION_DECODE)
        exec_instr <= prog_rdata;
    end
  end

endmodule
